// File: rtl/operand_accumulator_if.sv
// Operand/result handshake bundle for operand_accumulator.
// The slave modport is the accumulator; the master modport is whoever feeds it
// operands and consumes the result.
interface operand_accumulator_if #(
  parameter int N_BITS   = 8,
  parameter int CNT_BITS = 4
);
  logic                i_start;
  logic [CNT_BITS-1:0] i_length;
  logic                i_data_valid;
  logic [N_BITS-1:0]   i_data;
  logic                o_data_ready;
  logic [N_BITS-1:0]   o_sum;
  logic                o_overflow;
  logic                o_sum_valid;
  logic                i_sum_ready;
  logic                o_busy;

  modport slave (
    input  i_start, i_length, i_data_valid, i_data, i_sum_ready,
    output o_data_ready, o_sum, o_overflow, o_sum_valid, o_busy
  );

  modport master (
    output i_start, i_length, i_data_valid, i_data, i_sum_ready,
    input  o_data_ready, o_sum, o_overflow, o_sum_valid, o_busy
  );
endinterface

// File: rtl/operand_accumulator.sv
// Sums a run of i_length unsigned operands and hands the result downstream
// with a valid/ready handshake.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for i_start; o_sum/o_overflow hold the last result
// S_ACCUM | accepting operands until the remaining count reaches zero
// S_DONE  | result presented on o_sum_valid until i_sum_ready
module operand_accumulator #(
  parameter int N_BITS   = 8,
  parameter int CNT_BITS = 4
) (
  input logic                   i_clk,
  input logic                   i_rst,
  operand_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [N_BITS-1:0]   acc;
  logic                ovf;
  logic [CNT_BITS-1:0] remaining;
  logic                data_ready;
  logic                sum_valid;
  logic                busy;
  logic                beat;
  logic                run_start;
  logic                last_beat;
  logic [N_BITS:0]     sum_ext;

  assign run_start = (state == S_IDLE) && bus.i_start;
  assign beat      = (state == S_ACCUM) && bus.i_data_valid;
  assign last_beat = beat && (remaining == CNT_BITS'(1));
  // One extra bit captures the carry out of each addition.
  assign sum_ext   = {1'b0, acc} + {1'b0, bus.i_data};

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode; handshake outputs depend on state only.
  always_comb begin
    state_nxt  = state;
    data_ready = 1'b0;
    sum_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.i_start) begin
          if (bus.i_length == '0) state_nxt = S_DONE;
          else                    state_nxt = S_ACCUM;
        end
      end
      S_ACCUM: begin
        data_ready = 1'b1;
        busy       = 1'b1;
        if (last_beat) state_nxt = S_DONE;
      end
      S_DONE: begin
        sum_valid = 1'b1;
        busy      = 1'b1;
        if (bus.i_sum_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Accumulator, sticky carry and beat counter; cleared only when a new run starts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= '0;
    end else if (run_start) begin
      acc       <= '0;
      ovf       <= 1'b0;
      remaining <= bus.i_length;
    end else if (beat) begin
      acc       <= sum_ext[N_BITS-1:0];
      ovf       <= ovf | sum_ext[N_BITS];
      remaining <= remaining - CNT_BITS'(1);
    end
  end

  assign bus.o_sum        = acc;
  assign bus.o_overflow   = ovf;
  assign bus.o_data_ready = data_ready;
  assign bus.o_sum_valid  = sum_valid;
  assign bus.o_busy       = busy;

endmodule

// File: tb/tb_operand_accumulator.sv
// Directed and randomized checks for operand_accumulator (N_BITS=8, CNT_BITS=4).
// Inputs change and outputs are sampled on the falling edge.
module tb_operand_accumulator;

  logic i_clk;
  logic i_rst;
  int   n_pass;
  int   n_total;

  operand_accumulator_if #(.N_BITS(8), .CNT_BITS(4)) bus ();

  operand_accumulator #(.N_BITS(8), .CNT_BITS(4)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic idle_inputs();
    bus.i_start      = 1'b0;
    bus.i_length     = '0;
    bus.i_data_valid = 1'b0;
    bus.i_data       = '0;
    bus.i_sum_ready  = 1'b0;
  endtask

  // Pulse i_start for one cycle; must be called from IDLE on a falling edge.
  task automatic do_start(input logic [3:0] len);
    bus.i_start  = 1'b1;
    bus.i_length = len;
    @(negedge i_clk);
    bus.i_start  = 1'b0;
  endtask

  // One valid beat; the block is in ACCUM so it transfers on the next edge.
  task automatic do_beat(input logic [7:0] d);
    bus.i_data_valid = 1'b1;
    bus.i_data       = d;
    @(negedge i_clk);
    bus.i_data_valid = 1'b0;
  endtask

  task automatic do_handshake();
    bus.i_sum_ready = 1'b1;
    @(negedge i_clk);
    bus.i_sum_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst            = 1'b1;
    bus.i_start      = 1'b1;
    bus.i_length     = 4'($urandom);
    bus.i_data_valid = 1'b1;
    bus.i_data       = 8'($urandom);
    bus.i_sum_ready  = 1'b1;
    repeat (3) @(negedge i_clk);
    n_total++;
    if ({bus.o_sum, bus.o_overflow, bus.o_sum_valid, bus.o_data_ready, bus.o_busy} !== 12'h000)
      $display("FAIL reset_outputs: sum=%0d ovf=%b sv=%b rdy=%b busy=%b, required all 0",
               bus.o_sum, bus.o_overflow, bus.o_sum_valid, bus.o_data_ready, bus.o_busy);
    else n_pass++;
    idle_inputs();
    i_rst = 1'b0;
    @(negedge i_clk);
    n_total++;
    if ({bus.o_busy, bus.o_data_ready, bus.o_sum_valid} !== 3'b000)
      $display("FAIL reset_release_idle: busy/rdy/sv=%b, required 000",
               {bus.o_busy, bus.o_data_ready, bus.o_sum_valid});
    else n_pass++;
  endtask

  task automatic test_basic();
    do_start(4'd3);
    n_total++;
    if ({bus.o_busy, bus.o_data_ready, bus.o_sum_valid} !== 3'b110)
      $display("FAIL basic_accum_state: busy/rdy/sv=%b, required 110",
               {bus.o_busy, bus.o_data_ready, bus.o_sum_valid});
    else n_pass++;
    do_beat(8'd10);
    do_beat(8'd20);
    n_total++;
    if (bus.o_sum_valid !== 1'b0)
      $display("FAIL basic_early_valid: o_sum_valid=%b, required 0", bus.o_sum_valid);
    else n_pass++;
    do_beat(8'd30);
    n_total++;
    if (bus.o_sum_valid !== 1'b1 || bus.o_data_ready !== 1'b0)
      $display("FAIL basic_latency: sv=%b rdy=%b, required sv=1 rdy=0",
               bus.o_sum_valid, bus.o_data_ready);
    else n_pass++;
    n_total++;
    if (bus.o_sum !== 8'd60 || bus.o_overflow !== 1'b0)
      $display("FAIL basic_sum: sum=%0d ovf=%b, required sum=60 ovf=0", bus.o_sum, bus.o_overflow);
    else n_pass++;
    do_handshake();
    n_total++;
    if (bus.o_busy !== 1'b0 || bus.o_sum_valid !== 1'b0 || bus.o_sum !== 8'd60)
      $display("FAIL basic_back_to_idle: busy=%b sv=%b sum=%0d, required busy=0 sv=0 sum=60",
               bus.o_busy, bus.o_sum_valid, bus.o_sum);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] ops [6];
    logic [7:0] exp_sum [3];
    logic       exp_ovf [3];
    ops = '{8'd255, 8'd1, 8'd200, 8'd100, 8'd1, 8'd1};
    exp_sum = '{8'd0, 8'd44, 8'd2};
    exp_ovf = '{1'b1, 1'b1, 1'b0};
    for (int r = 0; r < 3; r++) begin
      do_start(4'd2);
      do_beat(ops[2*r]);
      do_beat(ops[2*r+1]);
      n_total++;
      if (bus.o_sum_valid !== 1'b1 || bus.o_sum !== exp_sum[r] || bus.o_overflow !== exp_ovf[r])
        $display("FAIL wrap_run%0d: sv=%b sum=%0d ovf=%b, required sv=1 sum=%0d ovf=%b",
                 r, bus.o_sum_valid, bus.o_sum, bus.o_overflow, exp_sum[r], exp_ovf[r]);
      else n_pass++;
      do_handshake();
    end
  endtask

  task automatic test_zero_length();
    do_start(4'd0);
    n_total++;
    if (bus.o_sum_valid !== 1'b1 || bus.o_sum !== 8'd0 || bus.o_overflow !== 1'b0)
      $display("FAIL zero_len_result: sv=%b sum=%0d ovf=%b, required sv=1 sum=0 ovf=0",
               bus.o_sum_valid, bus.o_sum, bus.o_overflow);
    else n_pass++;
    bus.i_data_valid = 1'b1;
    bus.i_data       = 8'd99;
    @(negedge i_clk);
    bus.i_data_valid = 1'b0;
    n_total++;
    if (bus.o_data_ready !== 1'b0 || bus.o_sum !== 8'd0)
      $display("FAIL zero_len_no_beat: rdy=%b sum=%0d, required rdy=0 sum=0",
               bus.o_data_ready, bus.o_sum);
    else n_pass++;
    do_handshake();
  endtask

  task automatic test_back_to_back_backpressure();
    // 7 + 9 + 11 + 13 = 40, with idle gaps between beats.
    do_start(4'd4);
    do_beat(8'd7);
    bus.i_data = 8'd200;
    @(negedge i_clk);
    do_beat(8'd9);
    bus.i_data = 8'd250;
    repeat (2) @(negedge i_clk);
    do_beat(8'd11);
    do_beat(8'd13);
    for (int c = 0; c < 5; c++) begin
      bus.i_start  = 1'b1;
      bus.i_length = 4'd2;
      n_total++;
      if (bus.o_sum_valid !== 1'b1 || bus.o_sum !== 8'd40 || bus.o_overflow !== 1'b0 ||
          bus.o_data_ready !== 1'b0)
        $display("FAIL backpressure_hold%0d: sv=%b sum=%0d ovf=%b rdy=%b, required sv=1 sum=40 ovf=0 rdy=0",
                 c, bus.o_sum_valid, bus.o_sum, bus.o_overflow, bus.o_data_ready);
      else n_pass++;
      @(negedge i_clk);
    end
    bus.i_start = 1'b0;
    do_handshake();
    n_total++;
    if (bus.o_busy !== 1'b0 || bus.o_sum !== 8'd40)
      $display("FAIL backpressure_no_restart: busy=%b sum=%0d, required busy=0 sum=40",
               bus.o_busy, bus.o_sum);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    do_start(4'd4);
    do_beat(8'd3);
    do_beat(8'd4);
    #2;
    i_rst = 1'b1;
    #1;
    n_total++;
    if ({bus.o_sum, bus.o_overflow, bus.o_sum_valid, bus.o_data_ready, bus.o_busy} !== 12'h000)
      $display("FAIL reset_async: sum=%0d ovf=%b sv=%b rdy=%b busy=%b, required all 0",
               bus.o_sum, bus.o_overflow, bus.o_sum_valid, bus.o_data_ready, bus.o_busy);
    else n_pass++;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    do_start(4'd3);
    do_beat(8'd5);
    do_beat(8'd5);
    do_beat(8'd5);
    n_total++;
    if (bus.o_sum_valid !== 1'b1 || bus.o_sum !== 8'd15 || bus.o_overflow !== 1'b0)
      $display("FAIL reset_then_run: sv=%b sum=%0d ovf=%b, required sv=1 sum=15 ovf=0",
               bus.o_sum_valid, bus.o_sum, bus.o_overflow);
    else n_pass++;
    do_handshake();
  endtask

  task automatic test_random_runs();
    logic [7:0] ops [16];
    int         len;
    int         total;
    int         sent;
    int         cyc;
    logic [7:0] exp_sum;
    logic       exp_ovf;
    for (int r = 0; r < 500; r++) begin
      len   = $urandom_range(0, 15);
      total = 0;
      for (int i = 0; i < 16; i++) begin
        ops[i] = 8'($urandom);
        if (i < len) total += int'(ops[i]);
      end
      // Unsigned operands: a carry happens at some beat iff the true total exceeds 255.
      exp_sum = 8'(total % 256);
      exp_ovf = (total >= 256);
      do_start(4'(len));
      sent = 0;
      cyc  = 0;
      while (sent < len && cyc < 200) begin
        bus.i_start  = 1'($urandom_range(0, 1));
        bus.i_length = 4'($urandom);
        if (bus.o_data_ready && $urandom_range(0, 3) != 0) begin
          bus.i_data_valid = 1'b1;
          bus.i_data       = ops[sent];
          sent++;
        end else begin
          bus.i_data_valid = bus.o_data_ready ? 1'b0 : 1'($urandom_range(0, 1));
          bus.i_data       = 8'($urandom);
        end
        @(negedge i_clk);
        cyc++;
      end
      bus.i_data_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        bus.i_start = 1'($urandom_range(0, 1));
        @(negedge i_clk);
      end
      bus.i_start = 1'b0;
      n_total++;
      if (cyc >= 200 || bus.o_sum_valid !== 1'b1)
        $display("FAIL random_run%0d_done: sv=%b after %0d beats of %0d, required sv=1",
                 r, bus.o_sum_valid, sent, len);
      else n_pass++;
      n_total++;
      if (bus.o_sum !== exp_sum || bus.o_overflow !== exp_ovf)
        $display("FAIL random_run%0d_sum: len=%0d sum=%0d ovf=%b, required sum=%0d ovf=%b",
                 r, len, bus.o_sum, bus.o_overflow, exp_sum, exp_ovf);
      else n_pass++;
      do_handshake();
      if (bus.o_busy !== 1'b0) begin
        // The block is stuck; restore a known state so later runs stay meaningful.
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
      end
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    i_rst   = 1'b1;
    idle_inputs();
    @(negedge i_clk);
    test_reset();
    test_basic();
    test_wrap();
    test_zero_length();
    test_back_to_back_backpressure();
    test_reset_mid_run();
    test_random_runs();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/operand_accumulator.md
OPERAND_ACCUMULATOR -- requirements
Module: operand_accumulator

Interface
REQ-001 The block SHALL have parameter N_BITS, default 8, setting operand and sum width.
REQ-002 The block SHALL have parameter CNT_BITS, default 4, setting the width of the beat-count field.
REQ-003 The block SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port i_start, input, 1, starts a run when sampled high in IDLE.
REQ-006 The block SHALL have port i_length, input, CNT_BITS, number of operands to sum; sampled with i_start.
REQ-007 The block SHALL have port i_data_valid, input, 1, upstream operand valid.
REQ-008 The block SHALL have port i_data, input, N_BITS, unsigned operand.
REQ-009 The block SHALL have port o_data_ready, output, 1, block accepts an operand this cycle.
REQ-010 The block SHALL have port o_sum, output, N_BITS, accumulated result modulo 2**N_BITS.
REQ-011 The block SHALL have port o_overflow, output, 1, sticky flag: any addition in the run produced a carry out.
REQ-012 The block SHALL have port o_sum_valid, output, 1, o_sum/o_overflow valid for downstream.
REQ-013 The block SHALL have port i_sum_ready, input, 1, downstream accepts the result.
REQ-014 The block SHALL have port o_busy, output, 1, high in ACCUM and DONE.

Function
REQ-015 The block SHALL implement states IDLE, ACCUM, DONE; all outputs registered or decoded from state only.
REQ-016 In IDLE: o_data_ready=0, o_sum_valid=0, o_busy=0; o_sum and o_overflow hold their last values.
REQ-017 IDLE with i_start=1 and i_length!=0 SHALL clear accumulator and overflow, load the remaining counter with i_length, and enter ACCUM next cycle.
REQ-018 IDLE with i_start=1 and i_length==0 SHALL clear accumulator and overflow and enter DONE next cycle (sum 0, overflow 0).
REQ-019 i_start SHALL be ignored in ACCUM and DONE.
REQ-020 In ACCUM o_data_ready SHALL be 1; a beat transfers only on a cycle where i_data_valid=1 and o_data_ready=1.
REQ-021 On each transfer: acc <= (acc + i_data) mod 2**N_BITS using an N_BITS+1 bit sum; overflow <= overflow OR carry; remaining <= remaining-1.
REQ-022 Cycles with i_data_valid=0 in ACCUM SHALL leave acc, overflow and remaining unchanged.
REQ-023 The transfer that decrements remaining from 1 to 0 SHALL move the FSM to DONE; o_sum_valid rises the cycle after that last beat (latency 1 cycle).
REQ-024 In DONE: o_data_ready=0, o_sum_valid=1, o_sum and o_overflow stable until handshake.
REQ-025 DONE with i_sum_ready=1 SHALL complete the handshake and return to IDLE next cycle; i_sum_ready=0 holds DONE indefinitely.
REQ-026 Once set within a run, o_overflow SHALL stay 1 until the next run starts, even if later wraps cancel out.
REQ-027 Maximum run length SHALL be 2**CNT_BITS-1 beats; i_length is unsigned, no other limit.

Reset
REQ-028 i_rst=1 SHALL immediately (asynchronously) force IDLE, acc=0, overflow=0, remaining=0; o_sum=0, o_overflow=0, o_sum_valid=0, o_data_ready=0, o_busy=0.
REQ-029 Reset asserted mid-ACCUM or in DONE SHALL discard the partial/unconsumed result; the first run after reset release SHALL behave as from power-up.

Verification
REQ-030 Reset: assert i_rst with random inputs -> all outputs 0, state IDLE, o_data_ready=0.
REQ-031 Basic run: i_length=3, operands 10,20,30 back-to-back -> o_sum_valid one cycle after third beat, o_sum=60, o_overflow=0.
REQ-032 Wrap: N_BITS=8, i_length=2, operands 255,1 -> o_sum=0, o_overflow=1; then i_length=2, operands 200,100 then 1,1 run -> overflow 1 then 0 respectively (sticky cleared per run).
REQ-033 Zero length: i_start with i_length=0 -> o_sum_valid=1 next cycle, o_sum=0, o_overflow=0, no beats accepted.
REQ-034 Backpressure: i_length=4 with i_data_valid gaps, i_sum_ready low 5 cycles, i_start pulsed during DONE -> sum matches model, o_sum stable throughout DONE, no new run started.
REQ-035 Reset mid-run: reset after 2 of 4 beats -> outputs 0 immediately; subsequent run 5,5,5 (i_length=3) -> o_sum=15, o_overflow=0; plus 500 random runs checked against a reference sum/carry model.
